// File: rtl/ring_buffer_pkg.sv
// Shared sizing helpers and arbiter state type for the multi-channel ring buffer.
package ring_buffer_pkg;

   // Occupancy counter width: must hold 0..buf_size inclusive.
   function automatic int unsigned cnt_width(input int unsigned buf_size);
      return $clog2(buf_size) + 1;
   endfunction

   // Channel index width, never narrower than one bit.
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Default almost-full level: two entries short of full.
   function automatic int unsigned afull_default(input int unsigned buf_size);
      return buf_size - 2;
   endfunction

   typedef enum logic {
      ARB_FREE,
      ARB_LOCKED
   } arb_state_e;

endpackage

// File: rtl/ring_buffer_ch.sv
// One channel of the ring buffer: circular storage, head/tail pointers,
// occupancy count and synchronous flush.
module ring_buffer_ch import ring_buffer_pkg::*; #(
   parameter  int unsigned DATA_SIZE   = 32,
   parameter  int unsigned BUFFER_SIZE = 8,
   localparam int unsigned CW          = cnt_width(BUFFER_SIZE)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 rx_i,
   output logic                 rx_ack_o,
   input  logic [DATA_SIZE-1:0] data_i,
   input  logic                 pop_i,
   output logic [DATA_SIZE-1:0] data_o,
   output logic [CW-1:0]        count_o
);

   localparam int unsigned PW = $clog2(BUFFER_SIZE);

   logic [DATA_SIZE-1:0] mem_q [BUFFER_SIZE];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 push;
   logic                 pop;
   logic                 wr_en;

   // Pointer/count next state; flush overrides any same-cycle push or pop.
   always_comb begin
      rx_ack_o = (count_q < CW'(BUFFER_SIZE));
      push     = rx_i && rx_ack_o;
      pop      = pop_i && (count_q != '0);
      wr_en    = push && !flush_i;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) head_d = head_q + PW'(1);
         if (pop)  tail_d = tail_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[head_q] <= data_i;
   end

   assign data_o  = mem_q[tail_q];
   assign count_o = count_q;

endmodule

// File: rtl/ring_buffer_mc.sv
// Multi-channel ring buffer: NUM_CH independent FIFOs merged onto one
// first-word-fall-through output by a round-robin arbiter with grant lock.
module ring_buffer_mc import ring_buffer_pkg::*; #(
   parameter  int unsigned DATA_SIZE    = 32,
   parameter  int unsigned BUFFER_SIZE  = 8,
   parameter  int unsigned NUM_CH       = 4,
   parameter  int unsigned AFULL_THRESH = afull_default(BUFFER_SIZE),
   localparam int unsigned CW           = cnt_width(BUFFER_SIZE),
   localparam int unsigned CHW          = ch_width(NUM_CH)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_CH-1:0]           buf_rst_i,
   input  logic [NUM_CH-1:0]           rx_i,
   output logic [NUM_CH-1:0]           rx_ack_o,
   input  logic [NUM_CH*DATA_SIZE-1:0] data_i,
   output logic                        tx_o,
   input  logic                        tx_ack_i,
   output logic [DATA_SIZE-1:0]        data_o,
   output logic [CHW-1:0]              tx_ch_o,
   output logic [NUM_CH*CW-1:0]        count_o,
   output logic [NUM_CH-1:0]           almost_full_o
);

   logic [DATA_SIZE-1:0] ch_data  [NUM_CH];
   logic [CW-1:0]        ch_count [NUM_CH];
   logic [NUM_CH-1:0]    nonempty;
   logic [NUM_CH-1:0]    pop_vec;

   arb_state_e           state_q, state_d;
   logic [CHW-1:0]       rr_q, rr_d;
   logic [CHW-1:0]       lock_q, lock_d;
   logic [CHW-1:0]       sel;
   logic [CHW-1:0]       scan_idx;
   logic                 found;
   logic                 pop_fire;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ring_buffer_ch #(
         .DATA_SIZE   (DATA_SIZE),
         .BUFFER_SIZE (BUFFER_SIZE)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .flush_i  (buf_rst_i[g]),
         .rx_i     (rx_i[g]),
         .rx_ack_o (rx_ack_o[g]),
         .data_i   (data_i[g*DATA_SIZE +: DATA_SIZE]),
         .pop_i    (pop_vec[g]),
         .data_o   (ch_data[g]),
         .count_o  (ch_count[g])
      );
      assign nonempty[g]            = (ch_count[g] != '0);
      assign almost_full_o[g]       = (ch_count[g] >= CW'(AFULL_THRESH));
      assign count_o[g*CW +: CW]    = ch_count[g];
   end

   // Grant selection, output mux, pop steering and lock/round-robin next state.
   // A locked grant bypasses the scan so data_o cannot shift under a pending
   // consumer; a flush of the candidate channel prevents locking onto it.
   always_comb begin
      sel      = '0;
      scan_idx = '0;
      found    = 1'b0;
      if (state_q == ARB_LOCKED) begin
         sel = lock_q;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan_idx = CHW'((32'(rr_q) + i) % NUM_CH);
            if (!found && nonempty[scan_idx]) begin
               sel   = scan_idx;
               found = 1'b1;
            end
         end
      end

      tx_o     = |nonempty;
      pop_fire = tx_o && tx_ack_i;
      tx_ch_o  = sel;
      data_o   = ch_data[sel];
      pop_vec  = '0;
      if (pop_fire) pop_vec[sel] = 1'b1;

      rr_d = rr_q;
      if (pop_fire) rr_d = (sel == CHW'(NUM_CH - 1)) ? '0 : sel + CHW'(1);

      state_d = state_q;
      lock_d  = lock_q;
      unique case (state_q)
         ARB_FREE: begin
            if (tx_o && !tx_ack_i && !buf_rst_i[sel]) begin
               state_d = ARB_LOCKED;
               lock_d  = sel;
            end
         end
         ARB_LOCKED: begin
            if (pop_fire || buf_rst_i[lock_q]) state_d = ARB_FREE;
         end
         default: state_d = ARB_FREE;
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_FREE;
         rr_q    <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
      end
   end

endmodule

// File: tb/tb_ring_buffer_mc.sv
// Testbench for ring_buffer_mc: queue-based reference model with a
// transfer scoreboard checked by an independent monitor process.
module tb_ring_buffer_mc;

   localparam int unsigned DW  = 32;
   localparam int unsigned BS  = 8;
   localparam int unsigned NC  = 4;
   localparam int unsigned CW  = 4;
   localparam int unsigned CHW = 2;
   localparam int unsigned AF  = BS - 2;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [NC-1:0]     buf_rst_i = '0;
   logic [NC-1:0]     rx_i = '0;
   logic [NC-1:0]     rx_ack_o;
   logic [NC*DW-1:0]  data_i = '0;
   logic              tx_o;
   logic              tx_ack_i = 1'b0;
   logic [DW-1:0]     data_o;
   logic [CHW-1:0]    tx_ch_o;
   logic [NC*CW-1:0]  count_o;
   logic [NC-1:0]     almost_full_o;

   ring_buffer_mc #(
      .DATA_SIZE   (DW),
      .BUFFER_SIZE (BS),
      .NUM_CH      (NC)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .buf_rst_i     (buf_rst_i),
      .rx_i          (rx_i),
      .rx_ack_o      (rx_ack_o),
      .data_i        (data_i),
      .tx_o          (tx_o),
      .tx_ack_i      (tx_ack_i),
      .data_o        (data_o),
      .tx_ch_o       (tx_ch_o),
      .count_o       (count_o),
      .almost_full_o (almost_full_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int unsigned   ch;
      logic [DW-1:0] data;
   } xfer_t;

   xfer_t         exp_q [$];
   logic [DW-1:0] mq [NC][$];
   int unsigned   m_rr       = 0;
   bit            m_locked   = 1'b0;
   int unsigned   m_lock_ch  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_any();
      for (int c = 0; c < NC; c++) if (mq[c].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Round-robin grant from the model: held channel if locked, else first
   // non-empty channel at or after the round-robin pointer.
   function automatic int unsigned m_grant();
      if (m_locked) return m_lock_ch;
      for (int i = 0; i < NC; i++) begin
         int unsigned c;
         c = (m_rr + i) % NC;
         if (mq[c].size() != 0) return c;
      end
      return 0;
   endfunction

   function automatic logic [NC*DW-1:0] rnd_data();
      logic [NC*DW-1:0] d;
      for (int c = 0; c < NC; c++) d[c*DW +: DW] = $urandom();
      return d;
   endfunction

   task automatic check_outputs();
      logic [NC-1:0]    e_ack, e_af;
      logic [NC*CW-1:0] e_cnt;
      int unsigned      g;
      for (int c = 0; c < NC; c++) begin
         e_cnt[c*CW +: CW] = CW'(mq[c].size());
         e_ack[c]          = (mq[c].size() < BS);
         e_af[c]           = (mq[c].size() >= AF);
      end
      check("tx_o", tx_o, m_any());
      check("rx_ack_o", rx_ack_o, e_ack);
      check("count_o", count_o, e_cnt);
      check("almost_full_o", almost_full_o, e_af);
      if (m_any()) begin
         g = m_grant();
         check("tx_ch_o", tx_ch_o, g);
         check("data_o", data_o, mq[g][0]);
      end
   endtask

   // One clock of stimulus: check current outputs, drive inputs, then
   // advance the model to the state after the coming rising edge.
   task automatic step(input logic [NC-1:0] rx, input logic [NC-1:0] fl,
                       input logic ack, input logic [NC*DW-1:0] din);
      bit          any;
      bit          pop;
      int unsigned g;
      int unsigned pre [NC];
      xfer_t       e;
      @(negedge clk_i);
      check_outputs();
      rx_i      = rx;
      buf_rst_i = fl;
      tx_ack_i  = ack;
      data_i    = din;
      any = m_any();
      g   = m_grant();
      pop = any && ack;
      if (pop) begin
         e.ch   = g;
         e.data = mq[g][0];
         exp_q.push_back(e);
      end
      for (int c = 0; c < NC; c++) pre[c] = mq[c].size();
      for (int c = 0; c < NC; c++) begin
         if (fl[c]) begin
            mq[c].delete();
         end else begin
            if (pop && g == c) void'(mq[c].pop_front());
            if (rx[c] && pre[c] < BS) mq[c].push_back(din[c*DW +: DW]);
         end
      end
      if (pop) m_rr = (g + 1) % NC;
      if (pop) m_locked = 1'b0;
      else if (any && !fl[g]) begin
         m_locked  = 1'b1;
         m_lock_ch = g;
      end else m_locked = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_tx_o", tx_o, 1'b0);
      check("rst_rx_ack_o", rx_ack_o, 4'hF);
      check("rst_count_o", count_o, '0);
      check("rst_almost_full_o", almost_full_o, 4'h0);
      check("rst_tx_ch_o", tx_ch_o, 2'd0);
   endtask

   // Asynchronous reset pulse asserted between clock edges.
   task automatic do_reset();
      @(negedge clk_i);
      rx_i      = '0;
      buf_rst_i = '0;
      tx_ack_i  = 1'b0;
      data_i    = '0;
      #1 rst_ni = 1'b0;
      #1 check_reset_outputs();
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_rr     = 0;
      m_locked = 1'b0;
      @(negedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 80 && m_any(); k++) step('0, '0, 1'b1, rnd_data());
      step('0, '0, 1'b0, rnd_data());
   endtask

   // Scoreboard monitor: every handshake the DUT presents must match the
   // oldest expected transfer.
   initial begin
      forever begin
         xfer_t e;
         @(negedge clk_i);
         #2;
         if (rst_ni === 1'b1 && tx_o === 1'b1 && tx_ack_i === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_unexpected: got ch %0d data 0x%0h, required no transfer", tx_ch_o, data_o);
            end else begin
               e = exp_q.pop_front();
               check("sb_ch", tx_ch_o, e.ch);
               check("sb_data", data_o, e.data);
            end
         end
      end
   end

   initial begin
      logic [NC*DW-1:0] d;
      logic [NC-1:0]    fl;

      #1 check_reset_outputs();
      @(negedge clk_i);
      #1 rst_ni = 1'b1;

      // Fill ch0 past capacity, then drain in order.
      for (int i = 0; i < 9; i++) begin
         d = rnd_data();
         d[0 +: DW] = 32'hA0 + i;
         step(4'b0001, '0, 1'b0, d);
      end
      check("fill_rx_ack0", rx_ack_o[0], 1'b0);
      check("fill_count0", count_o[0 +: CW], 4'd8);
      check("fill_afull0", almost_full_o[0], 1'b1);
      drain();

      // One word per channel with ack held: grants in channel order.
      do_reset();
      d = rnd_data();
      for (int c = 0; c < NC; c++) d[c*DW +: DW] = 32'hB0 + c;
      step(4'hF, '0, 1'b1, d);
      for (int i = 0; i < 5; i++) step('0, '0, 1'b1, rnd_data());
      check("rr_idle_tx_o", tx_o, 1'b0);

      // Locked grant on ch2 while ch0/ch1 fill; next grant wraps to ch0.
      do_reset();
      d = rnd_data();
      d[2*DW +: DW] = 32'hC2;
      step(4'b0100, '0, 1'b0, d);
      for (int i = 0; i < 3; i++) step(4'b0011, '0, 1'b0, rnd_data());
      check("lock_ch", tx_ch_o, 2'd2);
      check("lock_data", data_o, 32'hC2);
      step('0, '0, 1'b1, rnd_data());
      step('0, '0, 1'b0, rnd_data());
      check("after_lock_ch", tx_ch_o, 2'd0);
      drain();

      // Steady push+pop on ch1 at count 4 across pointer wrap.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         d = rnd_data();
         d[1*DW +: DW] = 32'hD0 + i;
         step(4'b0010, '0, 1'b0, d);
      end
      for (int i = 0; i < 20; i++) begin
         d = rnd_data();
         d[1*DW +: DW] = 32'hD4 + i;
         step(4'b0010, '0, 1'b1, d);
      end
      check("steady_count1", count_o[1*CW +: CW], 4'd4);
      drain();

      // Flush of a locked channel during a push.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         d = rnd_data();
         d[1*DW +: DW] = 32'hE0 + i;
         step((i < 2) ? 4'b1010 : 4'b0010, '0, 1'b0, d);
      end
      step(4'b0010, 4'b0010, 1'b0, rnd_data());
      step('0, '0, 1'b0, rnd_data());
      check("flush_count1", count_o[1*CW +: CW], 4'd0);
      check("flush_count3", count_o[3*CW +: CW], 4'd2);
      check("flush_next_ch", tx_ch_o, 2'd3);
      drain();

      // Random traffic, reset mid-stream, then random again.
      for (int i = 0; i < 1500; i++) begin
         fl = ($urandom_range(0, 15) == 0) ? NC'(1 << $urandom_range(0, NC - 1)) : '0;
         step(NC'($urandom()), fl, ($urandom_range(0, 3) == 0), rnd_data());
      end
      do_reset();
      d = rnd_data();
      d[2*DW +: DW] = 32'h5A5A_0041;
      step(4'b0100, '0, 1'b0, d);
      step('0, '0, 1'b0, rnd_data());
      check("post_rst_tx_o", tx_o, 1'b1);
      check("post_rst_ch", tx_ch_o, 2'd2);
      check("post_rst_data", data_o, 32'h5A5A_0041);
      for (int i = 0; i < 1500; i++) begin
         fl = ($urandom_range(0, 31) == 0) ? NC'(1 << $urandom_range(0, NC - 1)) : '0;
         step(NC'($urandom()), fl, ($urandom_range(0, 3) != 0), rnd_data());
      end
      drain();
      #3;
      check("sb_pending", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
